// File: rtl/kmac_absorb_pad.sv
// Byte-stream absorber for the KMAC sponge: packs message bytes into rate-sized
// blocks and closes each message with the domain suffix plus pad10*1.
module kmac_absorb_pad #(
  parameter int          RATE_BYTES = 136,
  parameter logic [7:0]  SUFFIX     = 8'h04
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  input  logic                    in_keep,
  input  logic                    in_last,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [8*RATE_BYTES-1:0] blk_data,
  output logic                    blk_last
);

  localparam int                 IDX_W    = $clog2(RATE_BYTES + 1);
  localparam int                 BLK_W    = 8 * RATE_BYTES;
  localparam logic [IDX_W-1:0]   FULL_IDX = IDX_W'(RATE_BYTES);
  localparam logic [BLK_W-1:0]   PAD_BLK  = (BLK_W'(8'h80) << (BLK_W - 8)) | BLK_W'(SUFFIX);

  typedef enum logic {FILL, EMIT} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             pad_pending;

  logic [IDX_W-1:0] wr_idx;
  logic [BLK_W-1:0] fill_data;
  logic [BLK_W-1:0] term_data;

  // Handshake outputs come straight from the state register, so blk_ready
  // never reaches in_ready combinationally.
  assign in_ready  = (state == FILL);
  assign blk_valid = (state == EMIT);

  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    wr_idx    = idx + IDX_W'(in_keep);
    fill_data = blk_data;
    if (in_keep) fill_data[{idx, 3'b000} +: 8] = in_data;
    term_data = fill_data;
    if (wr_idx != FULL_IDX) term_data[{wr_idx, 3'b000} +: 8] = SUFFIX;
    // OR rather than overwrite so a suffix landing on the last byte keeps both bits.
    term_data[BLK_W-1 -: 8] = term_data[BLK_W-1 -: 8] | 8'h80;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      idx         <= '0;
      pad_pending <= 1'b0;
      blk_data    <= '0;
      blk_last    <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_valid) begin
            idx <= wr_idx;
            if (wr_idx == FULL_IDX) begin
              // Message ending exactly on a block edge still owes a pad-only block.
              blk_data    <= fill_data;
              blk_last    <= 1'b0;
              pad_pending <= in_last;
              state       <= EMIT;
            end else if (in_last) begin
              blk_data <= term_data;
              blk_last <= 1'b1;
              state    <= EMIT;
            end else begin
              blk_data <= fill_data;
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            if (pad_pending) begin
              blk_data    <= PAD_BLK;
              blk_last    <= 1'b1;
              pad_pending <= 1'b0;
            end else begin
              blk_data <= '0;
              blk_last <= 1'b0;
              idx      <= '0;
              state    <= FILL;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/kmac_absorb_pad.md
# kmac_absorb_pad

Streaming byte-to-block absorber with pad10*1 for the KMAC datapath. Accepts message bytes over a valid/ready stream, packs them into rate-sized blocks, and applies the domain suffix plus pad10*1 padding when the message ends. Sits directly downstream of the encoding/padding helpers and directly upstream of the Keccak-f permutation. Each emitted block is XORed into the sponge state by the consumer.

## Interface
- RATE_BYTES, default 136: sponge rate in bytes (136 for KMAC256, 168 for KMAC128); legal range 2..200.
- SUFFIX, default 8'h04: first padding byte. Domain bits "00" plus the leading pad '1', LSB-first.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  8  message byte.
- in_keep  input  1  in_data carries a byte. 0 with in_last=1 means the message ends with no byte on this beat.
- in_last  input  1  final beat of the message.
- blk_valid  output  1  blk_data holds a complete rate block.
- blk_ready  input  1  downstream accepts the block.
- blk_data  output  8*RATE_BYTES  block; byte i at bits [8i+7:8i] (Keccak lane little-endian).
- blk_last  output  1  block is the final, padded block of the message.

## Operation
- State machine has two states: FILL and EMIT. Register pad_pending (1 bit). Byte index idx has width $clog2(RATE_BYTES+1).
- FILL:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - in_keep=1: the byte is written at idx, then idx increments.
  - in_keep=0, in_last=0: the beat is consumed with no effect.
- Full block (write makes idx==RATE_BYTES):
  - Go to EMIT with blk_last=0.
  - If in_last is also set, set pad_pending=1.
- End of message (in_last accepted, block not full; final index is k):
  - byte k = SUFFIX.
  - byte RATE_BYTES-1 |= 8'h80. When k==RATE_BYTES-1, that byte becomes SUFFIX|8'h80 (8'h84 by default).
  - Every other unwritten byte is 0.
  - Go to EMIT with blk_last=1.
- EMIT:
  - in_ready=0, blk_valid=1.
  - On blk_ready, if pad_pending=1: load a pad-only block (byte0=SUFFIX, byte RATE_BYTES-1=8'h80, other bytes 0), set blk_last=1, clear pad_pending, stay in EMIT.
  - On blk_ready otherwise: clear the buffer to 0, set idx=0, blk_last=0, return to FILL.
- Any number of messages may be processed back-to-back. Message boundaries are carried only by blk_last.
- Reset mid-operation: the partial message and any pending block are discarded. No block is emitted for them.

## Timing
- Reset values:
  - state=FILL, idx=0, pad_pending=0.
  - in_ready=1, blk_valid=0, blk_last=0, blk_data=0.
- in_ready and blk_valid are decoded from registered state only. There is no combinational path from blk_ready to in_ready.
- blk_valid rises the cycle after the beat that completes or ends a block.
- The handshake completes in the cycle blk_valid && blk_ready.
  - in_ready returns to 1 on the next cycle.
  - A pad-only block appears with blk_valid held high continuously, one cycle after the first block's handshake.
- While blk_valid=1 and blk_ready=0, blk_data and blk_last stay stable. in_valid beats are not accepted and are not lost.
- Peak throughput: one byte per cycle in FILL. Per block, cost is RATE_BYTES beats plus at least 1 EMIT cycle.
- Boundary cases:
  - Message of length 0 → one pad-only block.
  - Message length a multiple of RATE_BYTES → data blocks followed by a pad-only block.
  - Message length ≡ RATE_BYTES-1 (mod RATE_BYTES) → final byte is SUFFIX|8'h80.
- in_keep=0 with in_last=1 after a full block has been emitted is treated the same as an empty tail. It produces a pad-only block.

## Test plan
All cases use the default parameters (RATE_BYTES=136, SUFFIX=8'h04).
- Empty message (single beat, keep=0, last=1) → one block, byte0=8'h04, byte135=8'h80, all other bytes 0, blk_last=1. blk_valid rises 1 cycle after the beat.
- Bytes 8'hAA, 8'hBB, 8'hCC, last on 8'hCC → bytes 0..2=AA BB CC, byte3=8'h04, byte135=8'h80, rest 0, blk_last=1.
- 135 bytes of 8'h11 → bytes 0..134=8'h11, byte135=8'h84, blk_last=1; exactly one block.
- 136 bytes 0..135 (value = index) → block 1 has byte i = i and blk_last=0. Block 2 is pad-only with blk_last=1, valid in the cycle after block 1's handshake.
- 300-byte message with blk_ready held low for 10 cycles at each EMIT and in_valid held high:
  - in_ready=0 and blk_data stable throughout each stall.
  - Exactly 3 blocks: 136, 136, then 28 bytes + 8'h04 at byte28 + 8'h80 at byte135, last=1.
  - No byte is dropped or duplicated.
- Assert rst_n low after 50 bytes, release, then send a 1-byte message 8'h5A → all outputs return to reset values during reset. Only one block appears: byte0=8'h5A, byte1=8'h04, byte135=8'h80, blk_last=1.
